// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU run-control block.
package cpu_clk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SLOW   = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_STEP = 2'b11
  } mode_e;

  // Run state requested by a mode switch setting.
  function automatic state_e mode_to_state(input mode_e m);
    case (m)
      MODE_RUN:  return ST_RUN;
      MODE_SLOW: return ST_SLOW;
      MODE_STEP: return ST_STEP;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter,
// debounced level and a registered one-cycle rising-edge pulse.
module btn_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // Count consecutive cycles the synchronized input disagrees with the level;
  // any agreement (a bounce) restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  // Synchronizer, stability counter, level and edge registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU run control: produces the core clock enable for run / slow / step /
// halt operation, the display scan tick and the retired-cycle counter.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int SLOW_DIV  = 100_000_000,
  parameter int SCAN_DIV  = 100_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  mode_i,
  input  logic        step_btn_i,
  input  logic        halt_req_i,
  output logic        cpu_en_o,
  output logic        scan_tick_o,
  output logic [2:0]  state_o,
  output logic [31:0] cycle_cnt_o
);

  localparam int PW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]    mode_s1_q, mode_s2_q;
  state_e        state_q, state_d;
  logic          cpu_en_q, cpu_en_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          scan_tick_q, scan_tick_d;
  logic [31:0]   cycle_cnt_q, cycle_cnt_d;
  logic          halt_hit;
  logic          btn_level, btn_rise;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .btn_i  (step_btn_i),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  // Next state, next enable, prescaler, cycle counter and scan divider.
  always_comb begin
    state_d     = state_q;
    cpu_en_d    = 1'b0;
    presc_d     = presc_q;
    cycle_cnt_d = cycle_cnt_q;
    halt_hit    = halt_req_i && cpu_en_q;

    if (halt_hit) begin
      state_d = ST_HALTED;
    end else if (state_q == ST_HALTED) begin
      if (mode_e'(mode_s2_q) == MODE_IDLE) state_d = ST_IDLE;
    end else begin
      state_d = mode_to_state(mode_e'(mode_s2_q));
    end

    case (state_q)
      ST_RUN:  cpu_en_d = 1'b1;
      ST_SLOW: cpu_en_d = (presc_q == PW'(SLOW_DIV - 1));
      ST_STEP: cpu_en_d = btn_rise && btn_level;
      default: cpu_en_d = 1'b0;
    endcase
    if (halt_hit) cpu_en_d = 1'b0;

    if (state_d != state_q) begin
      presc_d = '0;
    end else if (state_q == ST_SLOW) begin
      presc_d = (presc_q == PW'(SLOW_DIV - 1)) ? '0 : presc_q + PW'(1);
    end

    if (state_q == ST_IDLE) begin
      cycle_cnt_d = '0;
    end else begin
      cycle_cnt_d = cycle_cnt_q + 32'(cpu_en_d);
    end

    scan_tick_d = (scan_q == SW'(SCAN_DIV - 1));
    scan_d      = scan_tick_d ? '0 : scan_q + SW'(1);
  end

  // Mode synchronizer and all run-control state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mode_s1_q   <= 2'b00;
      mode_s2_q   <= 2'b00;
      state_q     <= ST_IDLE;
      cpu_en_q    <= 1'b0;
      presc_q     <= '0;
      scan_q      <= '0;
      scan_tick_q <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      mode_s1_q   <= mode_i;
      mode_s2_q   <= mode_s1_q;
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      presc_q     <= presc_d;
      scan_q      <= scan_d;
      scan_tick_q <= scan_tick_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_en_o    = cpu_en_q;
  assign scan_tick_o = scan_tick_q;
  assign state_o     = state_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run-control block for the single-cycle CPU. It owns the CPU's clock resource: the core runs on the board clock, and this block produces a clock enable `cpu_en_o` that gates every architectural state update in the core. It supports four modes: full-rate run, slow (about 1 Hz) run, single-step from a push button, and halt. It also produces the 1 kHz display-scan tick and a retired-cycle counter for the LED/7-segment debug display.

## Interface
- `SLOW_DIV`, default 100_000_000: clk_i cycles between enable pulses in slow mode.
- `SCAN_DIV`, default 100_000: clk_i cycles between scan_tick_o pulses.
- `DB_CYCLES`, default 1_000_000: cycles the synchronized button must be stable before it is accepted.
- `clk_i`  in  1  board clock; the only clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `mode_i`  in  2  switch input, asynchronous: 00 idle, 01 run, 10 slow, 11 step.
- `step_btn_i`  in  1  raw step button, asynchronous, active-high.
- `halt_req_i`  in  1  from the core; high while a halt instruction is executing.
- `cpu_en_o`  out  1  registered CPU clock enable.
- `scan_tick_o`  out  1  registered one-cycle pulse every SCAN_DIV cycles.
- `state_o`  out  3  FSM state: 0 IDLE, 1 RUN, 2 SLOW, 3 STEP, 4 HALTED.
- `cycle_cnt_o`  out  32  count of cycles in which cpu_en_o was high.

## Operation
**Synchronizers**
- mode_i and step_btn_i each pass through a 2-flop synchronizer.

**Debouncer**
- The debounced button level changes only after the synchronized input has differed from it for DB_CYCLES consecutive cycles.
- Any bounce restarts the stability count.

**FSM (IDLE, RUN, SLOW, STEP, HALTED)**
- In IDLE, RUN, SLOW and STEP, the next state is the one selected by the synchronized mode.
- Halt condition: halt_req_i is high in a cycle where cpu_en_o is high. On that edge the state goes to HALTED. This has priority over a simultaneous mode change.
- HALTED exits only when the synchronized mode is 00, going to IDLE.

**cpu_en_o, next value by state**
- RUN: 1.
- SLOW: 1 when the prescaler equals SLOW_DIV-1. The prescaler then wraps to 0.
- STEP: 1 on the rising edge of the debounced button.
- IDLE and HALTED: 0.
- The halt condition forces the next value to 0. The halting instruction's cycle is therefore the last enabled cycle.

**Prescaler**
- Cleared on every state change.
- Counts only while the state is SLOW.

**Button edges**
- A debounced rising edge is acted on only if the state is STEP on that edge. Otherwise it is discarded, never queued.

**cycle_cnt_o**
- Increments on each cycle where cpu_en_o is high.
- Wraps from 0xFFFF_FFFF to 0.
- Cleared while the state is IDLE.

**scan_tick_o**
- Free-running and independent of the FSM.

## Timing
**Reset values** (asynchronous on rst_i low, including mid-operation):
- cpu_en_o 0, scan_tick_o 0, state_o 0, cycle_cnt_o 0.
- Prescaler, scan counter and debounce counter 0.
- Debounced button level 0.

**Latencies**
- mode_i change to state_o: 3 edges (2 synchronizer edges, then the state edge).
- mode_i change to first cpu_en_o in RUN: 4 edges.
- Button: 2 synchronizer edges, plus DB_CYCLES, plus 1 edge for the pulse. The pulse is exactly 1 cycle wide.

**SLOW mode**
- Pulses are exactly SLOW_DIV cycles apart.
- The first pulse comes SLOW_DIV cycles after the state enters SLOW.

**scan_tick_o**
- First pulse in cycle SCAN_DIV after reset release, then every SCAN_DIV cycles.

**Boundary cases**
- A button held through reset release produces exactly one step after debounce, if the state is STEP at that time.
- halt_req_i while cpu_en_o is low is ignored.

## Structure
- Package `cpu_clk_ctrl_pkg` holds:
  - the state encoding: IDLE=0, RUN=1, SLOW=2, STEP=3, HALTED=4;
  - the mode encoding: 00, 01, 10, 11.
- Sub-module `btn_debounce` contains the 2-flop synchronizer, the stability counter (parameter DB_CYCLES), the level output and a rising-edge output.
- The mode synchronizer stays inline in `cpu_clk_ctrl`.
- The prescaler, scan counter, cycle counter and FSM live in the top module.

## Test plan
All scenarios use SLOW_DIV=4, SCAN_DIV=5, DB_CYCLES=3.
1. Reset, then mode_i=01 for 10 cycles -> state_o=1 after 3 edges; cpu_en_o high from edge 4; cycle_cnt_o=7 after the tenth edge.
2. mode_i=10 -> cpu_en_o pulses every 4 cycles, exactly 1 cycle wide; switching to 01 mid-count clears the prescaler.
3. mode_i=11; button bounces 1-0-1, then is held for 5 cycles -> exactly one cpu_en_o pulse; a press made in mode 00 produces no pulse.
4. RUN with halt_req_i high for one enabled cycle while mode_i changes to 10 -> state_o=4, cpu_en_o=0 next cycle; mode 10 and 11 keep HALTED; mode 00 goes to IDLE and clears cycle_cnt_o.
5. scan_tick_o after reset -> pulses at cycles 5, 10 and 15, unaffected by mode changes or halt.
6. Assert rst_i low while in RUN with cycle_cnt_o=0xFFFF_FFFE -> all outputs 0 immediately; a separate run past 0xFFFF_FFFF wraps the count to 0.
